// File: rtl/soc_bus_ctrl.sv
// soc_bus_ctrl: region decode, delayed read-data steering, wait states and write gating for external slots.
// Latency: selects and wr_o are combinational; a waited slot stalls EXTn_WAIT cycles and completes in DONE.
// Backpressure: stall_o holds the processor; SOC_BUS_CTRL_BUS_ERR_EN adds sticky unmapped-access capture.
module soc_bus_ctrl #(
    parameter logic [7:0] PERIPH_TAG = 8'hE1,
    parameter logic [7:0] EXT0_TAG   = 8'hE2,
    parameter logic [7:0] EXT1_TAG   = 8'hE4,
    parameter int         EXT0_WAIT  = 2,
    parameter int         EXT1_WAIT  = 0,
    parameter int         WAIT_W     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  we_i,
    output logic        stall_o,
    output logic        sel_boot_o,
    output logic        sel_ram_n_o,
    output logic        sel_periph_o,
    output logic        sel_ext0_o,
    output logic        sel_ext1_o,
    output logic        wr_o,
    input  logic [31:0] data_boot_i,
    input  logic [31:0] data_ram_i,
    input  logic [31:0] data_periph_i,
    input  logic [31:0] data_ext0_i,
    input  logic [31:0] data_ext1_i,
    output logic [31:0] data_o,
    input  logic        err_clr_i,
    output logic        err_o,
    output logic [31:0] err_addr_o
);

    localparam bit EXT0_WAITED = (EXT0_WAIT > 0);
    localparam bit EXT1_WAITED = (EXT1_WAIT > 0);
    localparam logic [WAIT_W-1:0] EXT0_LOAD = EXT0_WAITED ? WAIT_W'(EXT0_WAIT - 1) : '0;
    localparam logic [WAIT_W-1:0] EXT1_LOAD = EXT1_WAITED ? WAIT_W'(EXT1_WAIT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] cnt, cnt_nxt;
    logic [31:0]       last_addr;
    logic              last_valid;
    logic              ram_dly, periph_dly, ext0_dly, ext1_dly;
    logic              hit_boot, hit_ram, hit_periph, hit_ext0, hit_ext1;
    logic              wsel0, wsel1, wsel, new_acc;
    logic              we_any, wr_direct, wr_wait;

    always_comb begin
        hit_boot   = (addr_i[31:28] == 4'h0);
        hit_ram    = (addr_i[31:28] == 4'h4);
        hit_periph = (addr_i[31:24] == PERIPH_TAG);
        hit_ext0   = (addr_i[31:24] == EXT0_TAG);
        hit_ext1   = (addr_i[31:24] == EXT1_TAG);
    end

    assign sel_boot_o   = hit_boot;
    assign sel_ram_n_o  = ~hit_ram;
    assign sel_periph_o = hit_periph;
    assign sel_ext0_o   = hit_ext0;
    assign sel_ext1_o   = hit_ext1;

    assign we_any  = (we_i != 4'h0);
    assign wsel0   = hit_ext0 & EXT0_WAITED;
    assign wsel1   = hit_ext1 & EXT1_WAITED;
    assign wsel    = wsel0 | wsel1;
    // A re-read of the address that just completed does not stall again.
    assign new_acc = (addr_i != last_addr) | we_any | ~last_valid;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_wait   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wsel && new_acc) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = wsel1 ? EXT1_LOAD : EXT0_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt - WAIT_W'(1);
                end
            end
            ST_DONE: begin
                wr_wait   = we_any;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign stall_o = (state == ST_WAIT);

    // Waited slots only ever see the single DONE-cycle pulse.
    assign wr_direct = we_any & (hit_periph | (hit_ext0 & ~EXT0_WAITED) | (hit_ext1 & ~EXT1_WAITED));
    assign wr_o      = wr_direct | wr_wait;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_addr  <= '0;
            last_valid <= 1'b0;
        end else if (state == ST_DONE) begin
            last_addr  <= addr_i;
            last_valid <= 1'b1;
        end else if (!wsel) begin
            last_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ram_dly    <= 1'b0;
            periph_dly <= 1'b0;
            ext0_dly   <= 1'b0;
            ext1_dly   <= 1'b0;
        end else if (!stall_o) begin
            ram_dly    <= hit_ram;
            periph_dly <= hit_periph;
            ext0_dly   <= hit_ext0;
            ext1_dly   <= hit_ext1;
        end
    end

`ifdef SOC_BUS_CTRL_BUS_ERR_EN
    logic        hit_none;
    logic        err_q;
    logic [31:0] err_addr_q;

    assign hit_none = ~(hit_boot | hit_ram | hit_periph | hit_ext0 | hit_ext1);

    // A new unmapped access takes priority over a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (hit_none) begin
            err_q <= 1'b1;
            if (!err_q) begin
                err_addr_q <= addr_i;
            end
        end else if (err_clr_i) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end
    end

    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
    assign err_o          = 1'b0;
    assign err_addr_o     = '0;
`endif

    always_comb begin
        data_o = data_ram_i;
        if (hit_ext1 | ext1_dly) begin
            data_o = data_ext1_i;
        end else if (hit_ext0 | ext0_dly) begin
            data_o = data_ext0_i;
        end else if (hit_periph | periph_dly) begin
            data_o = data_periph_i;
        end else if (hit_boot & ~ram_dly) begin
            data_o = data_boot_i;
`ifdef SOC_BUS_CTRL_BUS_ERR_EN
        end else if (hit_none) begin
            data_o = 32'hDEAD_BEEF;
`endif
        end
    end

endmodule

// File: tb/tb_soc_bus_ctrl.sv
// Bench for soc_bus_ctrl: directed steps then randomized accesses against a transaction-level model.
module tb_soc_bus_ctrl;

    localparam int EXT0_W = 2;
    localparam int EXT1_W = 0;
`ifdef SOC_BUS_CTRL_BUS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int R_BOOT = 0;
    localparam int R_RAM  = 1;
    localparam int R_PER  = 2;
    localparam int R_EXT0 = 3;
    localparam int R_EXT1 = 4;
    localparam int R_NONE = 5;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] addr_i;
    logic [3:0]  we_i;
    logic        stall_o, sel_boot_o, sel_ram_n_o, sel_periph_o, sel_ext0_o, sel_ext1_o, wr_o;
    logic [31:0] data_boot_i, data_ram_i, data_periph_i, data_ext0_i, data_ext1_i, data_o;
    logic        err_clr_i, err_o;
    logic [31:0] err_addr_o;

    int checks   = 0;
    int failures = 0;

    int          prev_r;
    logic        m_last_valid;
    logic [31:0] m_last_addr;
    logic        m_err;
    logic [31:0] m_err_addr;

    always #5 clk_i = ~clk_i;

    soc_bus_ctrl #(
        .PERIPH_TAG(8'hE1), .EXT0_TAG(8'hE2), .EXT1_TAG(8'hE4),
        .EXT0_WAIT(EXT0_W), .EXT1_WAIT(EXT1_W), .WAIT_W(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .we_i(we_i), .stall_o(stall_o),
        .sel_boot_o(sel_boot_o), .sel_ram_n_o(sel_ram_n_o), .sel_periph_o(sel_periph_o),
        .sel_ext0_o(sel_ext0_o), .sel_ext1_o(sel_ext1_o), .wr_o(wr_o),
        .data_boot_i(data_boot_i), .data_ram_i(data_ram_i), .data_periph_i(data_periph_i),
        .data_ext0_i(data_ext0_i), .data_ext1_i(data_ext1_i), .data_o(data_o),
        .err_clr_i(err_clr_i), .err_o(err_o), .err_addr_o(err_addr_o)
    );

    function automatic int region_of(input logic [31:0] a);
        if (a[31:28] == 4'h0) return R_BOOT;
        if (a[31:28] == 4'h4) return R_RAM;
        if (a[31:24] == 8'hE1) return R_PER;
        if (a[31:24] == 8'hE2) return R_EXT0;
        if (a[31:24] == 8'hE4) return R_EXT1;
        return R_NONE;
    endfunction

    function automatic bit is_waited(input int r);
        return (r == R_EXT0 && EXT0_W > 0) || (r == R_EXT1 && EXT1_W > 0);
    endfunction

    // Read data seen for an access, given this access's region and the previous one's.
    function automatic logic [31:0] exp_data(input int cur, input int prev);
        if (cur == R_EXT1 || prev == R_EXT1) return data_ext1_i;
        if (cur == R_EXT0 || prev == R_EXT0) return data_ext0_i;
        if (cur == R_PER || prev == R_PER) return data_periph_i;
        if (cur == R_BOOT && prev != R_RAM) return data_boot_i;
        if (cur == R_NONE && ERR_EN) return 32'hDEAD_BEEF;
        return data_ram_i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rand_data();
        data_boot_i   = $urandom;
        data_ram_i    = $urandom;
        data_periph_i = $urandom;
        data_ext0_i   = $urandom;
        data_ext1_i   = $urandom;
    endtask

    task automatic model_reset();
        prev_r       = R_NONE;
        m_last_valid = 1'b0;
        m_last_addr  = '0;
        m_err        = 1'b0;
        m_err_addr   = '0;
    endtask

    task automatic model_edge(input int cur, input logic [31:0] a, input logic clr);
        if (ERR_EN) begin
            if (cur == R_NONE) begin
                if (!m_err) m_err_addr = a;
                m_err = 1'b1;
            end else if (clr) begin
                m_err      = 1'b0;
                m_err_addr = '0;
            end
        end
    endtask

    // One processor access: drive, check, follow any stall to completion.
    task automatic access(input logic [31:0] a, input logic [3:0] we, input logic clr);
        int cur;
        int n;
        bit stall_exp;
        addr_i    = a;
        we_i      = we;
        err_clr_i = clr;
        #1;
        cur = region_of(a);
        chk("err_o", {31'b0, err_o}, {31'b0, m_err});
        chk("err_addr", err_addr_o, m_err_addr);
        chk("selects", {27'b0, sel_boot_o, sel_ram_n_o, sel_periph_o, sel_ext0_o, sel_ext1_o},
            {27'b0, cur == R_BOOT, cur != R_RAM, cur == R_PER, cur == R_EXT0, cur == R_EXT1});
        stall_exp = is_waited(cur) && (we != 4'h0 || !m_last_valid || a != m_last_addr);
        chk("stall_first", {31'b0, stall_o}, 32'd0);
        if (!stall_exp) begin
            chk("wr", {31'b0, wr_o},
                {31'b0, we != 4'h0 && (cur == R_PER || cur == R_EXT0 || cur == R_EXT1)});
            chk("data", data_o, exp_data(cur, prev_r));
            if (!is_waited(cur)) m_last_valid = 1'b0;
            model_edge(cur, a, clr);
            prev_r = cur;
            tick();
        end else begin
            chk("wr_idle", {31'b0, wr_o}, 32'd0);
            model_edge(cur, a, clr);
            tick();
            n = 0;
            while (stall_o === 1'b1 && n < 16) begin
                chk("wr_in_wait", {31'b0, wr_o}, 32'd0);
                n++;
                model_edge(cur, a, clr);
                tick();
            end
            chk("stall_cycles", n, (cur == R_EXT0) ? EXT0_W : EXT1_W);
            chk("wr_done", {31'b0, wr_o}, {31'b0, we != 4'h0});
            chk("data_done", data_o, exp_data(cur, cur));
            m_last_addr  = a;
            m_last_valid = 1'b1;
            model_edge(cur, a, clr);
            prev_r = cur;
            tick();
        end
    endtask

    initial begin
        logic [31:0] a, last_a;
        logic [3:0]  we;
        logic        clr;
        int          r;

        rst_i     = 1'b0;
        addr_i    = 32'hE200_0000;
        we_i      = 4'h0;
        err_clr_i = 1'b0;
        rand_data();
        model_reset();
        repeat (3) tick();
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        chk("rst_err", {31'b0, err_o}, 32'd0);
        chk("rst_err_addr", err_addr_o, 32'd0);
        chk("rst_wr", {31'b0, wr_o}, 32'd0);
        chk("rst_data", data_o, data_ext0_i);

        // Release with EXT0 still addressed: stall begins on the next edge.
        rst_i = 1'b1;
        access(32'hE200_0000, 4'h0, 1'b0);

        rand_data();
        data_ext0_i = 32'h1234_5678;
        access(32'hE200_0010, 4'h0, 1'b0);
        access(32'hE200_0010, 4'hF, 1'b0);
        access(32'hE200_0010, 4'h0, 1'b0);
        access(32'hE200_0010, 4'h0, 1'b0);

        rand_data();
        access(32'hE400_0000, 4'h0, 1'b0);
        access(32'h4000_0100, 4'h0, 1'b0);
        access(32'h4000_0100, 4'h0, 1'b0);
        access(32'hE400_0008, 4'h3, 1'b0);
        access(32'hE100_0004, 4'h1, 1'b0);
        access(32'h0000_0040, 4'h0, 1'b0);
        access(32'h4000_0000, 4'h0, 1'b0);
        access(32'h0000_0040, 4'h0, 1'b0);
        access(32'h0000_0044, 4'h0, 1'b0);

        // Reset during the wait: stall drops at once, no write strobe appears.
        addr_i = 32'hE200_0200;
        we_i   = 4'hF;
        #1;
        chk("mid_idle_stall", {31'b0, stall_o}, 32'd0);
        tick();
        chk("mid_wait_stall", {31'b0, stall_o}, 32'd1);
        chk("mid_wait_wr", {31'b0, wr_o}, 32'd0);
        #2;
        rst_i = 1'b0;
        #1;
        chk("mid_rst_stall", {31'b0, stall_o}, 32'd0);
        chk("mid_rst_wr", {31'b0, wr_o}, 32'd0);
        addr_i = 32'h0000_0000;
        we_i   = 4'h0;
        tick();
        tick();
        chk("mid_rst_wr_held", {31'b0, wr_o}, 32'd0);
        rst_i = 1'b1;
        model_reset();

        rand_data();
        access(32'h0000_0010, 4'h0, 1'b0);
        access(32'h8000_0004, 4'h0, 1'b0);
`ifdef SOC_BUS_CTRL_BUS_ERR_EN
        chk("err_set", {31'b0, err_o}, 32'd1);
        chk("err_addr_first", err_addr_o, 32'h8000_0004);
        access(32'h9000_0000, 4'h0, 1'b0);
        chk("err_addr_kept", err_addr_o, 32'h8000_0004);
        access(32'h0000_0100, 4'h0, 1'b1);
        chk("err_cleared", {31'b0, err_o}, 32'd0);
        chk("err_addr_cleared", err_addr_o, 32'd0);
`else
        chk("err_disabled", {31'b0, err_o}, 32'd0);
        access(32'h0000_0100, 4'h0, 1'b1);
        chk("err_addr_disabled", err_addr_o, 32'd0);
`endif

        last_a = 32'h0000_0100;
        for (int i = 0; i < 200; i++) begin
            rand_data();
            r = $urandom_range(0, 5);
            case (r)
                R_BOOT:  a = {4'h0, 28'($urandom)};
                R_RAM:   a = {4'h4, 28'($urandom)};
                R_PER:   a = {8'hE1, 24'($urandom)};
                R_EXT0:  a = {8'hE2, 16'h0, 4'($urandom), 4'h0};
                R_EXT1:  a = {8'hE4, 16'h0, 4'($urandom), 4'h0};
                default: a = ($urandom_range(0, 1) == 0) ? {4'h8, 28'($urandom)} : {8'hE3, 24'($urandom)};
            endcase
            if ($urandom_range(0, 9) < 4) a = last_a;
            we  = ($urandom_range(0, 9) < 3) ? 4'($urandom_range(1, 15)) : 4'h0;
            clr = ($urandom_range(0, 9) < 2);
            access(a, we, clr);
            last_a = a;
        end

        err_clr_i = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
